// File: rtl/fp_mul_minmax_unit.sv
// Multi-cycle floating-point unit: iterative shift-add multiply with round-to-nearest-even,
// plus single-pass MIN/MAX and sign injection, with valid/ready handshakes on both sides.
module fp_mul_minmax_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             op_i,
    input  logic [EXP_W+MAN_W:0]   operand1_i,
    input  logic [EXP_W+MAN_W:0]   operand2_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic [4:0]             flags_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int PW    = 2 * SIG_W;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 2);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MIN   = 3'd1;
    localparam logic [2:0] OP_MAX   = 3'd2;
    localparam logic [2:0] OP_SGNJ  = 3'd3;
    localparam logic [2:0] OP_SGNJN = 3'd4;
    localparam logic [2:0] OP_SGNJX = 3'd5;

    localparam logic signed [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [4:0] FLAG_NV = 5'b10000;
    localparam logic [4:0] FLAG_OF = 5'b00100;
    localparam logic [4:0] FLAG_UF = 5'b00010;
    localparam logic [4:0] FLAG_NX = 5'b00001;

    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

    // Normalise the raw product, round to nearest-even and saturate; returns {flags, result}.
    function automatic logic [W+4:0] round_rne(input logic [PW-1:0] prod,
                                              input logic signed [EW-1:0] exp_in,
                                              input logic sgn);
        logic [PW-1:0]          norm;
        logic [SIG_W-1:0]       top;
        logic [SIG_W:0]         rnd;
        logic                   guard, sticky, up;
        logic [MAN_W-1:0]       man;
        logic signed [EW-1:0]   exp_f;
        norm   = prod[PW-1] ? prod : (prod << 1);
        top    = norm[PW-1 -: SIG_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        up     = guard & (sticky | top[0]);
        rnd    = {1'b0, top} + {{SIG_W{1'b0}}, up};
        man    = rnd[SIG_W] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_f  = exp_in + $signed({{(EW-1){1'b0}}, prod[PW-1]})
                        + $signed({{(EW-1){1'b0}}, rnd[SIG_W]});
        if (exp_f >= EXP_MAX)
            round_rne = {FLAG_OF | FLAG_NX, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (exp_f <= 0)
            round_rne = {FLAG_UF | FLAG_NX, sgn, {(W-1){1'b0}}};
        else
            round_rne = {{4'b0000, guard | sticky}, sgn, exp_f[EXP_W-1:0], man};
    endfunction

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, a_lt_b;

    assign sa     = operand1_i[W-1];
    assign sb     = operand2_i[W-1];
    assign ea     = operand1_i[W-2 -: EXP_W];
    assign eb     = operand2_i[W-2 -: EXP_W];
    assign ma     = operand1_i[MAN_W-1:0];
    assign mb     = operand2_i[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    // Sign-magnitude ordering; -0 sorts below +0 because the sign decides first.
    assign a_lt_b = (sa != sb) ? sa
                  : (sa ? (operand1_i[W-2:0] > operand2_i[W-2:0])
                        : (operand1_i[W-2:0] < operand2_i[W-2:0]));

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]         acc_q, acc_d, mcand_q, mcand_d;
    logic [SIG_W-1:0]      mplier_q, mplier_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic                  sign_q, sign_d;
    logic [W-1:0]          result_q, result_d, quick_res;
    logic [4:0]            flags_q, flags_d, quick_flags;
    logic                  mul_fast;
    logic [W+4:0]          rnd_out;

    assign rnd_out = round_rne(acc_q, exp_q, sign_q);

    always_comb begin
        quick_res   = CANON_NAN;
        quick_flags = '0;
        mul_fast    = 1'b1;
        case (op_i)
            OP_MUL: begin
                if (a_nan || b_nan)
                    quick_flags = (a_snan || b_snan) ? FLAG_NV : '0;
                else if ((a_inf && b_zero) || (b_inf && a_zero))
                    quick_flags = FLAG_NV;
                else if (a_inf || b_inf)
                    quick_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (a_zero || b_zero)
                    quick_res = {sa ^ sb, {(W-1){1'b0}}};
                else
                    mul_fast = 1'b0;
            end
            OP_MIN, OP_MAX: begin
                quick_flags = (a_snan || b_snan) ? FLAG_NV : '0;
                if (a_nan && b_nan)  quick_res = CANON_NAN;
                else if (a_nan)      quick_res = operand2_i;
                else if (b_nan)      quick_res = operand1_i;
                else                 quick_res = ((op_i == OP_MIN) == a_lt_b) ? operand1_i : operand2_i;
            end
            OP_SGNJ:  quick_res = {sb, operand1_i[W-2:0]};
            OP_SGNJN: quick_res = {~sb, operand1_i[W-2:0]};
            OP_SGNJX: quick_res = {sa ^ sb, operand1_i[W-2:0]};
            default:  quick_flags = FLAG_NV;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: if (valid_i) begin
                result_d = quick_res;
                flags_d  = quick_flags;
                state_d  = DONE;
                if (op_i == OP_MUL && !mul_fast) begin
                    state_d  = MUL;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{SIG_W{1'b0}}, 1'b1, ma};
                    mplier_d = {1'b1, mb};
                    exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    sign_d   = sa ^ sb;
                end
            end
            // One multiplier bit per cycle, LSB first.
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MAN_W))
                    state_d = ROUND;
            end
            ROUND: begin
                result_d = rnd_out[W-1:0];
                flags_d  = rnd_out[W+4:W];
                cnt_d    = '0;
                state_d  = DONE;
            end
            DONE: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        exp_q    <= exp_d;
        sign_q   <= sign_d;
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign flags_o  = flags_q;
endmodule

// File: tb/tb_fp_mul_minmax_unit.sv
// Randomised bench for fp_mul_minmax_unit with a behavioural single-precision reference model.
module tb_fp_mul_minmax_unit;
    localparam logic [31:0] CANON = 32'h7FC00000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  op_i = '0;
    logic [31:0] operand1_i = '0, operand2_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    fp_mul_minmax_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i),
        .operand1_i(operand1_i), .operand2_i(operand2_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .result_o(result_o), .flags_o(flags_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int order_key(input logic [31:0] x);
        return x[31] ? (-int'(x[30:0]) - 1) : int'(x[30:0]);
    endfunction

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
        logic a_z, b_z, a_i, b_i, a_n, b_n, a_sn, b_sn, s;
        longint unsigned p, q, rem, half;
        int e, sh;
        a_z = (a[30:23] == 8'h00);  b_z = (b[30:23] == 8'h00);
        a_i = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_i = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_n = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_n = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_sn = a_n && !a[22];  b_sn = b_n && !b[22];
        s = a[31] ^ b[31];
        r = CANON; f = 5'h00;
        case (op)
            3'd0: begin
                if (a_n || b_n) f = (a_sn || b_sn) ? 5'h10 : 5'h00;
                else if ((a_i && b_z) || (b_i && a_z)) f = 5'h10;
                else if (a_i || b_i) r = {s, 8'hFF, 23'h0};
                else if (a_z || b_z) r = {s, 31'h0};
                else begin
                    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
                    e = int'(a[30:23]) + int'(b[30:23]) - 127;
                    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
                    else sh = 23;
                    q    = p >> sh;
                    rem  = p & ((64'd1 << sh) - 1);
                    half = 64'd1 << (sh - 1);
                    if (rem > half || (rem == half && q[0])) q++;
                    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
                    if (e >= 255)      begin r = {s, 8'hFF, 23'h0}; f = 5'h05; end
                    else if (e <= 0)   begin r = {s, 31'h0};        f = 5'h03; end
                    else begin
                        r = {s, e[7:0], q[22:0]};
                        f = (rem != 0) ? 5'h01 : 5'h00;
                    end
                end
            end
            3'd1, 3'd2: begin
                f = (a_sn || b_sn) ? 5'h10 : 5'h00;
                if (a_n && b_n) r = CANON;
                else if (a_n)   r = b;
                else if (b_n)   r = a;
                else if (op == 3'd1) r = (order_key(a) <= order_key(b)) ? a : b;
                else                 r = (order_key(a) >= order_key(b)) ? a : b;
            end
            3'd3: r = {b[31], a[30:0]};
            3'd4: r = {~b[31], a[30:0]};
            3'd5: r = {s, a[30:0]};
            default: f = 5'h10;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: x = {x[31], 31'h0};
            1: x = {x[31], 8'hFF, 23'h0};
            2: x = {x[31], 8'hFF, 1'b1, x[21:0]};
            3: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
            4, 5: x[30:23] = 8'd120 + 8'($urandom_range(0, 14));
            default: begin
                if (x[30:23] == 8'h00) x[30:23] = 8'h01;
                if (x[30:23] == 8'hFF) x[30:23] = 8'hFE;
            end
        endcase
        return x;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
        check_eq("ready_before_issue", 32'(ready_o), 32'd1);
    endtask

    // Issue one request, follow it to the result, hold off the consumer for 'hold' cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] got_r, output logic [4:0] got_f);
        logic [31:0] er;
        logic [4:0]  ef;
        int lat, want_lat;
        bit rdy_bad, unstable;
        model(op, a, b, er, ef);
        want_lat = (op == 3'd0 && a[30:23] != 8'h00 && a[30:23] != 8'hFF
                    && b[30:23] != 8'h00 && b[30:23] != 8'hFF) ? 26 : 1;
        wait_ready();
        op_i = op; operand1_i = a; operand2_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1; rdy_bad = 0;
        while (!valid_o && lat < 100) begin
            if (ready_o) rdy_bad = 1;
            @(posedge clk_i); #1; lat++;
        end
        check_eq("valid_seen", 32'(valid_o), 32'd1);
        check_eq("latency", 32'(lat), 32'(want_lat));
        check_eq("ready_low_busy", 32'(rdy_bad), 32'd0);
        check_eq("result", result_o, er);
        check_eq("flags", 32'(flags_o), 32'(ef));
        got_r = result_o; got_f = flags_o;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                valid_i = 1'b1; op_i = 3'd3;
                operand1_i = $urandom; operand2_i = $urandom;
            end
            @(posedge clk_i); #1;
            valid_i = 1'b0;
            if (result_o !== er || flags_o !== ef || !valid_o || ready_o) unstable = 1;
        end
        if (hold > 0) check_eq("hold_stable", 32'(unstable), 32'd0);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check_eq("post_hs_valid", 32'(valid_o), 32'd0);
        check_eq("post_hs_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ready", 32'(ready_o), 32'd1);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_result", result_o, 32'h0);
        check_eq("rst_flags", 32'(flags_o), 32'h0);
        rst_i = 1'b0;

        run_op(3'd0, 32'h3FC00000, 32'h40000000, 0, r, f);
        check_eq("t1_res", r, 32'h40400000);
        check_eq("t1_flg", 32'(f), 32'h00);
        run_op(3'd0, 32'h3F800001, 32'h3F800001, 0, r, f);
        check_eq("t2a_res", r, 32'h3F800002);
        check_eq("t2a_flg", 32'(f), 32'h01);
        run_op(3'd0, 32'h7F000000, 32'h7F000000, 0, r, f);
        check_eq("t2b_res", r, 32'h7F800000);
        check_eq("t2b_flg", 32'(f), 32'h05);
        run_op(3'd0, 32'h00800000, 32'h00800000, 0, r, f);
        check_eq("t2c_res", r, 32'h00000000);
        check_eq("t2c_flg", 32'(f), 32'h03);
        run_op(3'd0, 32'h7F800000, 32'h00000000, 0, r, f);
        check_eq("t3a_res", r, 32'h7FC00000);
        check_eq("t3a_flg", 32'(f), 32'h10);
        run_op(3'd0, 32'h7F800001, 32'h3F800000, 0, r, f);
        check_eq("t3b_res", r, 32'h7FC00000);
        check_eq("t3b_flg", 32'(f), 32'h10);
        run_op(3'd1, 32'h80000000, 32'h00000000, 0, r, f);
        check_eq("t4_min", r, 32'h80000000);
        run_op(3'd2, 32'h7FC00000, 32'h40000000, 0, r, f);
        check_eq("t4_max", r, 32'h40000000);
        check_eq("t4_max_flg", 32'(f), 32'h00);
        run_op(3'd5, 32'hBF800000, 32'hC0000000, 0, r, f);
        check_eq("t4_sgnjx", r, 32'h3F800000);
        run_op(3'd0, 32'h40400000, 32'h3FC00000, 10, r, f);
        check_eq("t5_res", r, 32'h40900000);
        run_op(3'd7, 32'h3F800000, 32'h3F800000, 0, r, f);
        check_eq("illegal_res", r, CANON);
        check_eq("illegal_flg", 32'(f), 32'h10);

        // Abort a multiply mid-iteration with reset.
        wait_ready();
        op_i = 3'd0; operand1_i = 32'h40400000; operand2_i = 32'h3FC00000; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; end
        check_eq("t6_busy_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_eq("t6_valid", 32'(valid_o), 32'd0);
        check_eq("t6_ready", 32'(ready_o), 32'd1);
        check_eq("t6_result", result_o, 32'h0);
        check_eq("t6_flags", 32'(flags_o), 32'h0);
        repeat (30) begin @(posedge clk_i); #1; end
        check_eq("t6_no_emit", 32'(valid_o), 32'd0);
        run_op(3'd0, 32'h40000000, 32'h40400000, 0, r, f);
        check_eq("t6_res", r, 32'h40C00000);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (i < 30) op = 3'd0;
            run_op(op, rand_operand(), rand_operand(), $urandom_range(0, 3), r, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
